dcache_ctrl: RTL
================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache with an integrated miss-handling state machine. It is the block the memory stage drives for every load and store. It answers hits in the same cycle. On a miss it asserts Stall, writes back a dirty victim line, fills the line word-by-word from backing memory over a req/ack handshake, then completes the access.

## Interface
Parameters:
- LINES, 8, number of cache lines; power of two, at least 2.
- WPL, 4, 16-bit words per line; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- Addr  in  16  byte address of the access; must be even
- DataIn  in  16  store data
- Rd  in  1  load request
- Wr  in  1  store request
- DataOut  out  16  load data; valid when Done=1 for a load
- Done  out  1  access complete this cycle
- Stall  out  1  miss in progress; requester holds its request and the pipeline freezes
- CacheHit  out  1  qualifies Done; 1 means completed without a memory transaction
- err  out  1  illegal request this cycle
- mem_addr  out  16  backing-memory word address (byte address, even)
- mem_wdata  out  16  backing-memory write data
- mem_rd  out  1  backing-memory read request
- mem_wr  out  1  backing-memory write request
- mem_rdata  in  16  backing-memory read data; valid with mem_ack
- mem_ack  in  1  backing-memory completes the current request

## Operation
- Address fields:
  - offset = Addr[log2(WPL):1]
  - index = the next log2(LINES) bits
  - tag = all remaining upper bits
- Per line: valid, dirty, tag, WPL data words.
- States and transitions:
  - IDLE to IDLE: request hits (valid and tags match).
    - Done=1 and CacheHit=1, combinationally in the same cycle.
    - Load: DataOut = addressed word.
    - Store: the word is written and dirty is set at the clock edge.
  - IDLE to WB: miss with a valid, dirty victim. Latch Addr, DataIn and the op; Stall=1.
  - IDLE to FILL: miss with a clean or invalid victim. Same latching; Stall=1.
  - WB: mem_wr=1, mem_addr = {victim tag, index, k, 0}, mem_wdata = victim word k, k = 0..WPL-1.
    - k advances on each mem_ack.
    - After the ack for k=WPL-1, go to FILL.
  - FILL: mem_rd=1, mem_addr = {new tag, index, k, 0}.
    - On each mem_ack, store mem_rdata into word k and advance k.
    - After the last ack: set valid, write the tag, clear dirty, go to CMPL.
  - CMPL: perform the latched op on the now-resident line.
    - Done=1, CacheHit=0 for one cycle.
    - A store sets dirty.
    - Return to IDLE.
- err=1 (combinational, IDLE only) when Rd&Wr, or when (Rd|Wr) with Addr[0]=1.
  - No access is made, Done stays 0, state is unchanged.
- Rd, Wr, Addr and DataIn are ignored in WB, FILL and CMPL; latched values govern.
- Stall=1 in WB and FILL. Stall=0 in IDLE and CMPL.

## Timing
- Reset values:
  - state IDLE; all valid and dirty bits 0; k=0.
  - Done, Stall, CacheHit, err, mem_rd, mem_wr all 0.
  - DataOut, mem_addr, mem_wdata all 0.
- Hit latency is 0 cycles: Done is asserted in the request cycle.
- Clean miss: request cycle, then WPL acked reads, then one CMPL cycle.
- Dirty miss: adds WPL acked writes ahead of the fill.
- Memory handshake:
  - mem_rd/mem_wr, mem_addr and mem_wdata stay stable until the edge at which mem_ack=1 is sampled.
  - The next word's request is presented the following cycle with no idle gap.
  - mem_rd and mem_wr are never both 1.
  - mem_ack while no request is outstanding is ignored.
- A victim whose tag and index equal the new address cannot occur: equality is a hit.
- Reset mid-WB or mid-FILL:
  - All requests drop immediately and all lines are invalidated.
  - Partially written backing data is not repaired.
- Counter k wraps WPL-1 to 0 on the state change.

## Structure
- Shared package dcache_pkg holds:
  - state encoding: IDLE, WB, FILL, CMPL
  - derived widths: OFS_W, IDX_W, TAG_W
- Sub-module dcache_array:
  - holds tag, valid, dirty and data storage
  - asynchronous read, synchronous write
  - asynchronous clear of valid and dirty on rst
- dcache_ctrl itself holds the FSM, the k counter and the request latches.

## Test plan
All scenarios use LINES=8, WPL=4.
- Cold-miss load:
  - Stimulus: after reset, Rd Addr=0x0010; memory returns 0x1111, 0x2222, 0x3333, 0x4444.
  - Required: Stall=1; mem_rd to 0x0010, 0x0012, 0x0014, 0x0016; then one CMPL cycle with Done=1, CacheHit=0, DataOut=0x1111.
- Load hit:
  - Stimulus: then Rd Addr=0x0014.
  - Required: same cycle Done=1, CacheHit=1, DataOut=0x3333; no mem_rd.
- Store hit then dirty eviction:
  - Stimulus: Wr 0x0012 with 0xBEEF (hit), then Rd 0x0210 (index 2, tag 8).
  - Required: mem_wr to 0x0010..0x0016 with data 0x1111, 0xBEEF, 0x3333, 0x4444; then mem_rd 0x0210..0x0216; then Done.
- Illegal requests:
  - Stimulus: Rd=Wr=1, or Rd with Addr=0x0011.
  - Required: err=1, Done=0, no memory request, state stays IDLE.
- Reset during fill:
  - Stimulus: rst after 2 FILL acks.
  - Required: mem_rd and Stall go to 0 asynchronously; a following Rd 0x0010 is a miss.
- Slow memory:
  - Stimulus: mem_ack delayed 3 cycles per word.
  - Required: mem_addr and mem_rd held stable and Stall=1 throughout; final DataOut correct.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        CMPL
    } state_e;

    localparam int ADDR_W    = 16;
    localparam int DEF_LINES = 8;
    localparam int DEF_WPL   = 4;

    function automatic int ofs_w(input int wpl);
        return $clog2(wpl);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Byte-address bit 0 is never part of a field.
    function automatic int tag_w(input int lines, input int wpl);
        return ADDR_W - 1 - $clog2(wpl) - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous write.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WPL   = DEF_WPL,
    localparam int OW   = ofs_w(WPL),
    localparam int IW   = idx_w(LINES),
    localparam int TW   = tag_w(LINES, WPL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] idx_i,
    input  logic [OW-1:0] ofs_i,
    output logic          valid_o,
    output logic          dirty_o,
    output logic [TW-1:0] tag_o,
    output logic [15:0]   rdata_o,
    input  logic          we_i,
    input  logic [15:0]   wdata_i,
    input  logic          dirty_set_i,
    input  logic          line_set_i,
    input  logic [TW-1:0] tag_i
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [15:0]      data_q [LINES][WPL];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign rdata_o = data_q[idx_i][ofs_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_set_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (dirty_set_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_set_i)
            tag_q[idx_i] <= tag_i;
        if (we_i)
            data_q[idx_i][ofs_i] <= wdata_i;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate data cache with miss-handling FSM.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WPL   = DEF_WPL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int OW = ofs_w(WPL);
    localparam int IW = idx_w(LINES);
    localparam int TW = tag_w(LINES, WPL);
    localparam logic [OW-1:0] K_LAST = OW'(WPL - 1);

    state_e        state_q, state_d;
    logic [OW-1:0] k_q, k_d;
    logic [14:0]   addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic          wr_q, wr_d;

    logic [14:0]   w;
    logic [IW-1:0] idx;
    logic [OW-1:0] ofs;
    logic [TW-1:0] tag;
    logic          req, hit;

    logic          a_valid, a_dirty, a_we, a_dset, a_lset;
    logic [TW-1:0] a_tag;
    logic [15:0]   a_rdata, a_wdata;

    // Live request fields in IDLE, latched ones while a miss is serviced.
    assign w   = (state_q == IDLE) ? Addr[15:1] : addr_q;
    assign idx = w[OW+IW-1:OW];
    assign tag = w[14:OW+IW];
    assign ofs = (state_q == WB || state_q == FILL) ? k_q : w[OW-1:0];

    assign req = Rd | Wr;
    assign err = (state_q == IDLE) && ((Rd & Wr) || (req && Addr[0]));
    assign hit = a_valid && (a_tag == tag);

    dcache_array #(
        .LINES(LINES),
        .WPL  (WPL)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx_i      (idx),
        .ofs_i      (ofs),
        .valid_o    (a_valid),
        .dirty_o    (a_dirty),
        .tag_o      (a_tag),
        .rdata_o    (a_rdata),
        .we_i       (a_we),
        .wdata_i    (a_wdata),
        .dirty_set_i(a_dset),
        .line_set_i (a_lset),
        .tag_i      (tag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = wr_q;
        Done      = 1'b0;
        Stall     = 1'b0;
        CacheHit  = 1'b0;
        DataOut   = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        a_we      = 1'b0;
        a_wdata   = DataIn;
        a_dset    = 1'b0;
        a_lset    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !err) begin
                    if (hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        if (Wr) begin
                            a_we   = 1'b1;
                            a_dset = 1'b1;
                        end else begin
                            DataOut = a_rdata;
                        end
                    end else begin
                        addr_d  = Addr[15:1];
                        data_d  = DataIn;
                        wr_d    = Wr;
                        state_d = (a_valid && a_dirty) ? WB : FILL;
                    end
                end
            end
            WB: begin
                Stall     = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {a_tag, idx, k_q, 1'b0};
                mem_wdata = a_rdata;
                if (mem_ack) begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_LAST)
                        state_d = FILL;
                end
            end
            FILL: begin
                Stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {tag, idx, k_q, 1'b0};
                if (mem_ack) begin
                    a_we    = 1'b1;
                    a_wdata = mem_rdata;
                    k_d     = k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        a_lset  = 1'b1;
                        state_d = CMPL;
                    end
                end
            end
            CMPL: begin
                Done    = 1'b1;
                state_d = IDLE;
                if (wr_q) begin
                    a_we    = 1'b1;
                    a_wdata = data_q;
                    a_dset  = 1'b1;
                end else begin
                    DataOut = a_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
